// File: rtl/adc_capture_pkg.sv
// Shared types for the ADC capture sequencer: FSM state encoding and drop-counter width.
package adc_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SYNC,
        ST_CAPTURE,
        ST_DRAIN
    } state_e;

    localparam int DROP_CNT_W = 16;

endpackage

// File: rtl/adc_sample_fifo.sv
// Sample buffer: first word visible one cycle after write, output held stable until read.
// A write at full is accepted only when a read frees a slot in the same cycle; otherwise it is refused.
module adc_sample_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             wr_vld_i,
    input  logic [WIDTH-1:0] wr_dat_i,
    input  logic             rd_rdy_i,
    output logic [WIDTH-1:0] rd_dat_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      cnt_q;
    logic             wr_fire, rd_fire;

    assign full_o   = (cnt_q == DEPTH_C);
    assign empty_o  = (cnt_q == '0);
    assign rd_fire  = rd_rdy_i && !empty_o;
    assign wr_fire  = wr_vld_i && (!full_o || rd_fire);
    // Gated so the output bus reads zero whenever nothing is presented.
    assign rd_dat_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (wr_fire) begin
            mem_q[wr_ptr_q] <= wr_dat_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (wr_fire) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (rd_fire) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({wr_fire, rd_fire})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/adc_capture_sequencer.sv
// Frames N packets (0 = until STOP) from a non-stallable ADC stream, aligned to packet boundaries; 1-cycle FIFO latency.
// Input never stalls: beats arriving with the FIFO full are dropped and flagged; ADC_CAPTURE_DROP_COUNT_EN adds DROP_COUNT.
module adc_capture_sequencer
    import adc_capture_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int FIFO_DEPTH  = 8,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   AXIS_ACLK,
    input  logic                   AXIS_ARESETN,
    input  logic                   START,
    input  logic                   STOP,
    input  logic [COUNT_WIDTH-1:0] NUM_PACKETS,
    output logic                   ADC_EN,
    input  logic                   S_AXIS_TVALID,
    input  logic [DATA_WIDTH-1:0]  S_AXIS_TDATA,
    input  logic                   S_AXIS_TLAST,
    output logic                   S_AXIS_TREADY,
    output logic                   M_AXIS_TVALID,
    output logic [DATA_WIDTH-1:0]  M_AXIS_TDATA,
    output logic                   M_AXIS_TLAST,
    input  logic                   M_AXIS_TREADY,
    output logic                   BUSY,
    output logic                   DONE,
    output logic                   OVERFLOW
`ifdef ADC_CAPTURE_DROP_COUNT_EN
    ,
    output logic [DROP_CNT_W-1:0]  DROP_COUNT
`endif
);

    state_e                 state_q, state_d;
    logic [1:0]             rst_sync_q;
    logic                   rst_n;
    logic [COUNT_WIDTH-1:0] num_pkt_q, pkt_cnt_q, pkt_cnt_inc;
    logic                   stop_pend_q, adc_en_q, busy_q, done_q, ovf_q;
    logic                   start_acc, in_last, last_pkt, cap_wr, rd_fire, drop;
    logic                   fifo_full, fifo_empty;

    // Reset asserts immediately, releases two clocks after AXIS_ARESETN rises.
    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end
    assign rst_n = rst_sync_q[1];

    assign start_acc   = (state_q == ST_IDLE) && START;
    assign in_last     = S_AXIS_TVALID && S_AXIS_TLAST;
    assign pkt_cnt_inc = pkt_cnt_q + 1'b1;
    assign last_pkt    = (num_pkt_q != '0) && (pkt_cnt_inc == num_pkt_q);
    assign cap_wr      = (state_q == ST_CAPTURE) && S_AXIS_TVALID;
    assign rd_fire     = M_AXIS_TVALID && M_AXIS_TREADY;
    assign drop        = cap_wr && fifo_full && !rd_fire;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (START) state_d = ST_SYNC;
            ST_SYNC:    if (STOP) state_d = ST_DRAIN;
                        else if (in_last) state_d = ST_CAPTURE;
            ST_CAPTURE: if (in_last && (last_pkt || stop_pend_q || STOP)) state_d = ST_DRAIN;
            ST_DRAIN:   if (fifo_empty) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge AXIS_ACLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            adc_en_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
            num_pkt_q   <= '0;
            pkt_cnt_q   <= '0;
            stop_pend_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            adc_en_q <= (state_d == ST_SYNC) || (state_d == ST_CAPTURE);
            busy_q   <= (state_d != ST_IDLE);
            done_q   <= (state_q == ST_DRAIN) && (state_d == ST_IDLE);
            if (start_acc) begin
                num_pkt_q   <= NUM_PACKETS;
                pkt_cnt_q   <= '0;
                stop_pend_q <= 1'b0;
                ovf_q       <= 1'b0;
            end else begin
                if (state_q == ST_CAPTURE) begin
                    if (in_last) pkt_cnt_q <= pkt_cnt_inc;
                    if (STOP) stop_pend_q <= 1'b1;
                end
                if (drop) ovf_q <= 1'b1;
            end
        end
    end

`ifdef ADC_CAPTURE_DROP_COUNT_EN
    logic [DROP_CNT_W-1:0] drop_cnt_q;

    always_ff @(posedge AXIS_ACLK or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= '0;
        end else if (start_acc) begin
            drop_cnt_q <= '0;
        end else if (drop && (drop_cnt_q != '1)) begin
            drop_cnt_q <= drop_cnt_q + 1'b1;
        end
    end
    assign DROP_COUNT = drop_cnt_q;
`endif

    adc_sample_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i    (AXIS_ACLK),
        .rst_ni   (rst_n),
        .wr_vld_i (cap_wr),
        .wr_dat_i ({S_AXIS_TLAST, S_AXIS_TDATA}),
        .rd_rdy_i (M_AXIS_TREADY),
        .rd_dat_o ({M_AXIS_TLAST, M_AXIS_TDATA}),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty)
    );

    assign M_AXIS_TVALID = !fifo_empty;
    assign S_AXIS_TREADY = 1'b1;
    assign ADC_EN        = adc_en_q;
    assign BUSY          = busy_q;
    assign DONE          = done_q;
    assign OVERFLOW      = ovf_q;

endmodule
